// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 serial transmitter.
// Bytes are queued in a small FIFO and shifted out LSB first, one bit every
// CLKS_PER_BIT clocks. Queued frames follow each other with no idle clock
// between the stop bit of one frame and the start bit of the next.
module uart_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Ready,
    output logic       o_TX_Serial,
    output logic       o_TX_Active,
    output logic       o_TX_Done
);

    localparam int DATA_W = 8;
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    fifo_cnt;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    // Ready is decoded from the registered count, so a write landing on a
    // full FIFO is ignored even if the transmitter pops in the same cycle.
    assign o_TX_Ready = (fifo_cnt != FIFO_FULL);
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = i_TX_DV && o_TX_Ready;

    // FIFO payload storage; data only, so it carries no reset.
    always_ff @(posedge i_Clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= i_TX_Byte;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [2:0]        idx_q;
    logic [2:0]        idx_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic              serial_d;
    logic              bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    // Sequencer state, bit timer, bit index and registered line level.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            o_TX_Serial <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            o_TX_Serial <= serial_d;
        end
    end

    // Frame shift register; loaded from the FIFO head on every pop.
    always_ff @(posedge i_Clk) begin
        shift_q <= shift_d;
    end

    // Next-state, FIFO pop and next line level; the line level is derived
    // from the next state so the start bit appears on the same edge that
    // pops the byte.
    always_comb begin
        state_d  = state_q;
        cnt_d    = bit_end ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        shift_d  = shift_q;
        pop      = 1'b0;
        serial_d = 1'b1;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr];
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_mem[rd_ptr];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        case (state_d)
            IDLE:    serial_d = 1'b1;
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[idx_d];
            STOP:    serial_d = 1'b1;
            default: serial_d = 1'b1;
        endcase
    end

    assign o_TX_Active = (state_q != IDLE);
    assign o_TX_Done   = (state_q == STOP) && bit_end;

endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered 8N1 UART transmitter: the send direction for the board's serial link, driving the top-level `TX` pin alongside the existing UART receiver on `RX`. Bytes written by upstream logic go into a small FIFO. They are serialized LSB-first at a fixed bit period of `CLKS_PER_BIT` clocks. Consecutive frames are sent back-to-back with no idle gap.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 217, clocks per bit (25 MHz / 115200 baud); legal range 2..65535.
- `FIFO_DEPTH`, default 4, FIFO entries; power of two, 2..16.

Ports:
- `i_Clk`  in  1  system clock; the block is fully synchronous to it.
- `i_Rst`  in  1  asynchronous, active-high reset.
- `i_TX_DV`  in  1  write strobe; one byte per cycle while high.
- `i_TX_Byte`  in  8  byte to write; sampled when `i_TX_DV` is high.
- `o_TX_Ready`  out  1  high when the FIFO is not full.
- `o_TX_Serial`  out  1  serial line, registered; idle level is 1.
- `o_TX_Active`  out  1  high while a frame is being shifted out.
- `o_TX_Done`  out  1  one-cycle pulse at the end of each frame's stop bit.

## Operation
- Frame format: one start bit (0), then 8 data bits with bit 0 first, then one stop bit (1). Each bit is held for exactly `CLKS_PER_BIT` clocks, so a frame is 10*`CLKS_PER_BIT` clocks.
- FIFO behaviour:
  - A write is accepted on a rising edge when `i_TX_DV`=1 and `o_TX_Ready`=1.
  - A write with `o_TX_Ready`=0 is dropped silently; FIFO contents are unchanged.
  - `o_TX_Ready` = (count != `FIFO_DEPTH`), decoded from the registered count.
  - A push and a pop in the same cycle are legal when the FIFO is not full; count is unchanged.
- Counters and widths:
  - Bit-clock counter width is clog2(`CLKS_PER_BIT`); it counts 0..`CLKS_PER_BIT`-1 and wraps.
  - Bit index is 3 bits, 0..7.
  - FIFO pointers are clog2(`FIFO_DEPTH`) bits and wrap naturally.
- State machine:
  - IDLE: `o_TX_Serial`=1, `o_TX_Active`=0. If the FIFO is non-empty: pop the head into the shift register, clear the counter, go to START.
  - START: `o_TX_Serial`=0. When the counter reaches `CLKS_PER_BIT`-1: clear the counter, set bit index to 0, go to DATA.
  - DATA: `o_TX_Serial`=shift[index]. On counter wrap: if index=7 go to STOP, else increment index.
  - STOP: `o_TX_Serial`=1. On the last clock, assert `o_TX_Done`. If the FIFO is non-empty, pop and go directly to START. Otherwise go to IDLE.
- `o_TX_Active` is high in START, DATA and STOP.
- Reset (asynchronous, any time, including mid-frame):
  - State goes to IDLE; FIFO is emptied; counters go to 0.
  - Outputs: `o_TX_Serial`=1 immediately, `o_TX_Active`=0, `o_TX_Done`=0, `o_TX_Ready`=1.
  - The partial frame is abandoned and is not resumed after reset.

## Timing
- Latency: write accepted at edge N while IDLE with the FIFO empty → `o_TX_Serial` falls at edge N+1.
- The start bit occupies edges N+1 .. N+`CLKS_PER_BIT`. The bit k line value changes at edge N+1+(k+1)*`CLKS_PER_BIT`.
- `o_TX_Done` is high for exactly one cycle: the final clock of the stop bit, 10*`CLKS_PER_BIT` clocks after the start edge.
- Back-to-back frames: the next start bit begins on the edge right after the stop bit ends, with zero idle clocks.
- Writes are accepted in every state, including during a frame.
- `o_TX_Ready` responds on the cycle after the count changes.

## Test plan
- Reset, idle line: assert `i_Rst` mid-DATA of a byte 0x00 → `o_TX_Serial`=1 with no clock edge, `o_TX_Active`=0, `o_TX_Ready`=1. No residual frame follows reset release.
- Single byte 0x01 (default parameters):
  - Line: low for 217 clocks, high for 217, low for 7×217, high for the stop bit.
  - `o_TX_Done` pulses once, 2170 clocks after the falling edge.
  - Loopback into the existing receiver yields RX byte 0x01.
- Patterns 0xA5 and 0xFF, loopback through the receiver → bytes 0xA5 and 0xFF received. Bit transitions land exactly every 217 clocks.
- FIFO fill: 6 writes (0x10..0x15) on consecutive cycles while IDLE:
  - 0x10..0x14 are accepted; 0x15 is dropped.
  - `o_TX_Ready` is low after the 5th write.
  - Five frames go out back-to-back with no idle gap; five `o_TX_Done` pulses, spaced 2170 clocks apart.
- Write during a frame: write 0x33 while 0x22 is in DATA → 0x33's start bit begins on the clock after 0x22's stop bit ends.
- Small divider: `CLKS_PER_BIT`=2, send 0x5A → each bit lasts 2 clocks and the frame lasts 20 clocks.
